// File: rtl/add_mul_ram_lift.sv
// Two-lane 5/3 integer wavelet lifting datapath with RAM write-back forwarding.
// Each lane produces registered even/odd write data one cycle after its operands.
module add_mul_ram_lift #(
    parameter int DW = 26,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_fwd_inv,
    input  logic          pix_even_odd,
    input  logic          pix_p,
    input  logic [DW-1:0] pix_dout_even,
    input  logic [DW-1:0] pix_dout_even1,
    input  logic [DW-1:0] pix_dout_odd,
    input  logic [DW-1:0] pix_dout_odd1,
    input  logic [DW-1:0] pix_left,
    input  logic [DW-1:0] pix_left1,
    input  logic [DW-1:0] pix_right,
    input  logic [DW-1:0] pix_right1,
    input  logic [AW-1:0] pix_addr_even,
    input  logic [AW-1:0] pix_addr_even1,
    input  logic [AW-1:0] pix_addr_odd,
    input  logic [AW-1:0] pix_addr_odd1,
    input  logic          pix_we_even,
    input  logic          pix_we_even1,
    input  logic          pix_we_odd,
    input  logic          pix_we_odd1,
    output logic [DW-1:0] pix_din_even,
    output logic [DW-1:0] pix_din_even1,
    output logic [DW-1:0] pix_din_odd,
    output logic [DW-1:0] pix_din_odd1
);

    localparam int NL = 2;
    localparam logic [DW+1:0] ROUND = {{DW{1'b0}}, 2'b10};

    logic [NL-1:0][DW-1:0] dout_even_s, dout_odd_s, left_s, right_s;
    logic [NL-1:0][AW-1:0] addr_even_s, addr_odd_s;
    logic [NL-1:0]         we_even_s, we_odd_s;
    logic [NL-1:0][DW-1:0] op_even_s, op_odd_s;
    logic [NL-1:0][DW-1:0] din_even_q, din_even_d, din_odd_q, din_odd_d;
    logic [NL-1:0][AW-1:0] last_addr_even_q, last_addr_odd_q;
    logic [NL-1:0]         last_we_even_q, last_we_odd_q;

    assign dout_even_s = {pix_dout_even1, pix_dout_even};
    assign dout_odd_s  = {pix_dout_odd1, pix_dout_odd};
    assign left_s      = {pix_left1, pix_left};
    assign right_s     = {pix_right1, pix_right};
    assign addr_even_s = {pix_addr_even1, pix_addr_even};
    assign addr_odd_s  = {pix_addr_odd1, pix_addr_odd};
    assign we_even_s   = {pix_we_even1, pix_we_even};
    assign we_odd_s    = {pix_we_odd1, pix_we_odd};

    // Predict: odd -/+ floor((l + r) / 2), wrapped to DW bits.
    function automatic logic [DW-1:0] predict_step(input logic [DW-1:0] x,
                                                   input logic [DW-1:0] l,
                                                   input logic [DW-1:0] r,
                                                   input logic fwd);
        logic signed [DW:0] s;
        logic signed [DW:0] p;
        s = $signed({l[DW-1], l}) + $signed({r[DW-1], r});
        p = s >>> 1'b1;
        if (fwd) begin
            return x - p[DW-1:0];
        end else begin
            return x + p[DW-1:0];
        end
    endfunction

    // Update: even +/- floor((l + r + 2) / 4), wrapped to DW bits.
    function automatic logic [DW-1:0] update_step(input logic [DW-1:0] x,
                                                  input logic [DW-1:0] l,
                                                  input logic [DW-1:0] r,
                                                  input logic fwd);
        logic signed [DW+1:0] t;
        logic signed [DW+1:0] u;
        t = $signed({{2{l[DW-1]}}, l}) + $signed({{2{r[DW-1]}}, r}) + $signed(ROUND);
        u = t >>> 2'd2;
        if (fwd) begin
            return x + u[DW-1:0];
        end else begin
            return x - u[DW-1:0];
        end
    endfunction

    // Operand select: a write to the same address last cycle is not yet visible in RAM.
    always_comb begin
        op_even_s = dout_even_s;
        op_odd_s  = dout_odd_s;
        for (int l = 0; l < NL; l++) begin
            if (last_we_even_q[l] && (last_addr_even_q[l] == addr_even_s[l])) begin
                op_even_s[l] = din_even_q[l];
            end else begin
                op_even_s[l] = dout_even_s[l];
            end
            if (last_we_odd_q[l] && (last_addr_odd_q[l] == addr_odd_s[l])) begin
                op_odd_s[l] = din_odd_q[l];
            end else begin
                op_odd_s[l] = dout_odd_s[l];
            end
        end
    end

    // Next-state lifting result per lane.
    always_comb begin
        din_even_d = din_even_q;
        din_odd_d  = din_odd_q;
        for (int l = 0; l < NL; l++) begin
            if (!pix_p) begin
                din_even_d[l] = din_even_q[l];
                din_odd_d[l]  = din_odd_q[l];
            end else if (pix_even_odd) begin
                din_even_d[l] = update_step(op_even_s[l], left_s[l], right_s[l], pix_fwd_inv);
                din_odd_d[l]  = op_odd_s[l];
            end else begin
                din_even_d[l] = op_even_s[l];
                din_odd_d[l]  = predict_step(op_odd_s[l], left_s[l], right_s[l], pix_fwd_inv);
            end
        end
    end

    // Output registers and forwarding history.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_even_q       <= '0;
            din_odd_q        <= '0;
            last_addr_even_q <= '0;
            last_addr_odd_q  <= '0;
            last_we_even_q   <= '0;
            last_we_odd_q    <= '0;
        end else begin
            din_even_q       <= din_even_d;
            din_odd_q        <= din_odd_d;
            last_addr_even_q <= addr_even_s;
            last_addr_odd_q  <= addr_odd_s;
            last_we_even_q   <= we_even_s;
            last_we_odd_q    <= we_odd_s;
        end
    end

    assign pix_din_even  = din_even_q[0];
    assign pix_din_even1 = din_even_q[1];
    assign pix_din_odd   = din_odd_q[0];
    assign pix_din_odd1  = din_odd_q[1];

endmodule

// File: tb/tb_add_mul_ram_lift.sv
// Scoreboard bench for add_mul_ram_lift: directed lifting cases plus randomized
// traffic checked against an arithmetic reference model with floor division.
module tb_add_mul_ram_lift;

    localparam int DW = 26;
    localparam int AW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, fwd, eo, p;
    logic [DW-1:0] ev [2];
    logic [DW-1:0] od [2];
    logic [DW-1:0] lf [2];
    logic [DW-1:0] rt [2];
    logic [AW-1:0] ae [2];
    logic [AW-1:0] ao [2];
    logic          we_e [2];
    logic          we_o [2];
    logic [DW-1:0] din_e0, din_e1, din_o0, din_o1;

    add_mul_ram_lift #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .pix_fwd_inv(fwd), .pix_even_odd(eo), .pix_p(p),
        .pix_dout_even(ev[0]), .pix_dout_even1(ev[1]),
        .pix_dout_odd(od[0]), .pix_dout_odd1(od[1]),
        .pix_left(lf[0]), .pix_left1(lf[1]),
        .pix_right(rt[0]), .pix_right1(rt[1]),
        .pix_addr_even(ae[0]), .pix_addr_even1(ae[1]),
        .pix_addr_odd(ao[0]), .pix_addr_odd1(ao[1]),
        .pix_we_even(we_e[0]), .pix_we_even1(we_e[1]),
        .pix_we_odd(we_o[0]), .pix_we_odd1(we_o[1]),
        .pix_din_even(din_e0), .pix_din_even1(din_e1),
        .pix_din_odd(din_o0), .pix_din_odd1(din_o1)
    );

    typedef struct {
        logic [DW-1:0] e0, e1, o0, o1;
    } exp_t;

    exp_t sb [$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: what the write-data registers should hold.
    logic [DW-1:0] m_e [2];
    logic [DW-1:0] m_o [2];
    logic [AW-1:0] m_la_e [2];
    logic [AW-1:0] m_la_o [2];
    logic          m_lw_e [2];
    logic          m_lw_o [2];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_push();
        exp_t e;
        for (int l = 0; l < 2; l++) begin
            logic [DW-1:0] oe, oo;
            longint s, r;
            if (rst) begin
                m_e[l] = '0; m_o[l] = '0;
                m_la_e[l] = '0; m_la_o[l] = '0;
                m_lw_e[l] = 1'b0; m_lw_o[l] = 1'b0;
            end else begin
                oe = (m_lw_e[l] && m_la_e[l] == ae[l]) ? m_e[l] : ev[l];
                oo = (m_lw_o[l] && m_la_o[l] == ao[l]) ? m_o[l] : od[l];
                if (p) begin
                    s = sx(lf[l]) + sx(rt[l]);
                    if (!eo) begin
                        r = fwd ? sx(oo) - floor_div(s, 2) : sx(oo) + floor_div(s, 2);
                        m_o[l] = r[DW-1:0];
                        m_e[l] = oe;
                    end else begin
                        r = fwd ? sx(oe) + floor_div(s + 2, 4) : sx(oe) - floor_div(s + 2, 4);
                        m_e[l] = r[DW-1:0];
                        m_o[l] = oo;
                    end
                end
                m_la_e[l] = ae[l]; m_la_o[l] = ao[l];
                m_lw_e[l] = we_e[l]; m_lw_o[l] = we_o[l];
            end
        end
        e.e0 = m_e[0]; e.e1 = m_e[1]; e.o0 = m_o[0]; e.o1 = m_o[1];
        sb.push_back(e);
    endtask

    // Directed cycle: both lanes get identical operands.
    task automatic dir_step(input logic r_i, input logic p_i, input logic fwd_i, input logic eo_i,
                            input logic [DW-1:0] e_i, input logic [DW-1:0] o_i,
                            input logic [DW-1:0] l_i, input logic [DW-1:0] r2_i,
                            input logic wo_i, input logic [AW-1:0] ao_i);
        @(negedge clk);
        rst = r_i; p = p_i; fwd = fwd_i; eo = eo_i;
        for (int l = 0; l < 2; l++) begin
            ev[l] = e_i; od[l] = o_i; lf[l] = l_i; rt[l] = r2_i;
            ae[l] = '0; ao[l] = ao_i; we_e[l] = 1'b0; we_o[l] = wo_i;
        end
        model_push();
    endtask

    task automatic rand_step(input logic r_i);
        @(negedge clk);
        rst = r_i; p = ($urandom_range(0, 3) != 0); fwd = 1'($urandom()); eo = 1'($urandom());
        for (int l = 0; l < 2; l++) begin
            ev[l] = DW'($urandom()); od[l] = DW'($urandom());
            lf[l] = DW'($urandom()); rt[l] = DW'($urandom());
            ae[l] = AW'($urandom_range(0, 3)); ao[l] = AW'($urandom_range(0, 3));
            we_e[l] = 1'($urandom()); we_o[l] = 1'($urandom());
        end
        model_push();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents fresh write data.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_din_even0", din_e0, e.e0);
                check("sb_din_even1", din_e1, e.e1);
                check("sb_din_odd0",  din_o0, e.o0);
                check("sb_din_odd1",  din_o1, e.o1);
            end
        end
    end

    initial begin
        rst = 1'b1; p = 1'b0; fwd = 1'b0; eo = 1'b0;
        for (int l = 0; l < 2; l++) begin
            ev[l] = '0; od[l] = '0; lf[l] = '0; rt[l] = '0;
            ae[l] = '0; ao[l] = '0; we_e[l] = 1'b0; we_o[l] = 1'b0;
            m_e[l] = '0; m_o[l] = '0; m_la_e[l] = '0; m_la_o[l] = '0;
            m_lw_e[l] = 1'b0; m_lw_o[l] = 1'b0;
        end

        // Reset with random inputs and p=1
        for (int i = 0; i < 2; i++) begin
            rand_step(1'b1);
            p = 1'b1;
            after_edge();
            check("rst_even0", din_e0, 26'd0);
            check("rst_odd0",  din_o0, 26'd0);
            check("rst_even1", din_e1, 26'd0);
            check("rst_odd1",  din_o1, 26'd0);
        end

        // Forward predict, both lanes
        dir_step(1'b0, 1'b1, 1'b1, 1'b0, 26'd7, 26'd100, 26'd40, 26'd61, 1'b0, 7'd0);
        after_edge();
        check("fwd_pred_odd0",  din_o0, 26'd50);
        check("fwd_pred_even0", din_e0, 26'd7);
        check("fwd_pred_odd1",  din_o1, 26'd50);
        check("fwd_pred_even1", din_e1, 26'd7);

        // Inverse predict round trip
        dir_step(1'b0, 1'b1, 1'b0, 1'b0, 26'd7, 26'd50, 26'd40, 26'd61, 1'b0, 7'd0);
        after_edge();
        check("inv_pred_odd0", din_o0, 26'd100);

        // Forward / inverse update with negative floor
        dir_step(1'b0, 1'b1, 1'b1, 1'b1, 26'd10, 26'd3, -26'sd7, -26'sd4, 1'b0, 7'd0);
        after_edge();
        check("fwd_upd_even0", din_e0, 26'd7);
        check("fwd_upd_odd0",  din_o0, 26'd3);
        dir_step(1'b0, 1'b1, 1'b0, 1'b1, 26'd7, 26'd3, -26'sd7, -26'sd4, 1'b0, 7'd0);
        after_edge();
        check("inv_upd_even1", din_e1, 26'd10);

        // Two's-complement wrap
        dir_step(1'b0, 1'b1, 1'b1, 1'b0, 26'd0, 26'd33554431, -26'sd2, -26'sd2, 1'b0, 7'd0);
        after_edge();
        check("wrap_odd0", din_o0, 26'h2000001);

        // Forwarding then hold
        dir_step(1'b0, 1'b1, 1'b1, 1'b0, 26'd0, 26'd20, 26'd0, 26'd0, 1'b1, 7'd5);
        after_edge();
        check("fwd_setup_odd0", din_o0, 26'd20);
        dir_step(1'b0, 1'b1, 1'b1, 1'b0, 26'd0, 26'd999, 26'd2, 26'd2, 1'b0, 7'd5);
        after_edge();
        check("forward_odd0", din_o0, 26'd18);
        check("forward_odd1", din_o1, 26'd18);
        for (int i = 0; i < 3; i++) begin
            dir_step(1'b0, 1'b0, 1'b1, 1'b0, 26'd1, 26'd999, 26'd9, 26'd9, 1'b0, 7'd5);
            after_edge();
            check("hold_odd0", din_o0, 26'd18);
        end

        // Randomized traffic with occasional mid-run reset
        for (int i = 0; i < 400; i++) begin
            rand_step($urandom_range(0, 29) == 0);
        end
        @(posedge clk);
        #3;
        check("sb_drained", DW'(sb.size()), 26'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
